// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes big-endian
// 32-bit words into instruction memory, and holds the core in reset until the image is complete.
module imem_boot_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] imem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error,
  output logic [15:0]      words_written
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t           state_q, state_d;
  logic [15:0]      n_q, n_d;
  logic [15:0]      k_q, k_d;
  logic [15:0]      ww_q, ww_d;
  logic [1:0]       b_q, b_d;
  // Holds the first three bytes of a word; the fourth byte completes it directly.
  logic [WIDTH-9:0] shift_q, shift_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]      n_next;
  logic             xfer;

  // Handshake depends on state only, so byte_ready never waits on byte_valid.
  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign n_next     = {n_q[15:8], byte_data};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    ww_d    = ww_q;
    b_d     = b_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          n_d     = {byte_data, n_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = n_next;
          if (n_next == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, n_next} > DEPTH_L) begin
            state_d = S_ERROR;
          end else begin
            k_d     = 16'd0;
            b_d     = 2'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d = {shift_q[WIDTH-17:0], byte_data};
          b_d     = b_q + 2'd1;
          if (b_q == 2'd3) begin
            // Output registers are loaded only here so they hold outside WRITE.
            addr_d  = WIDTH'({k_q, 2'b00});
            wdata_d = {shift_q, byte_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        k_d  = k_q + 16'd1;
        ww_d = ww_q + 16'd1;
        b_d  = 2'd0;
        if ((k_q + 16'd1) == n_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN_HI;
      n_q     <= '0;
      k_q     <= '0;
      ww_q    <= '0;
      b_q     <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      ww_q    <= ww_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we       = (state_q == S_WRITE);
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_rst       = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERROR);
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes are queued as bytes are
// sent and checked by a monitor whenever imem_we pulses.
module tb_imem_boot_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  logic             clk;
  logic             rst;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             imem_we;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_wdata;
  logic             cpu_rst;
  logic             done;
  logic             error;
  logic [15:0]      words_written;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  imem_boot_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
        $display("write addr=0x%08h data=0x%08h expected addr=0x%08h data=0x%08h",
                 imem_addr, imem_wdata, e.addr, e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input int gap);
    int cnt;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = d;
    cnt = 0;
    while (byte_ready !== 1'b1 && cnt < 64) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("byte_ready_before_accept", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit gaps);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    end
    chk("we_after_last_byte", 32'(imem_we), 32'd1);
  endtask

  task automatic send_len(input logic [15:0] n, input bit gaps);
    send_byte(n[15:8], gaps ? int'($urandom_range(0, 3)) : 0);
    send_byte(n[7:0], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic check_done(input logic [15:0] ww, input string tag);
    $display("%s: done=%0b cpu_rst=%0b byte_ready=%0b words_written=%0d", tag, done, cpu_rst,
             byte_ready, words_written);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words_written"}, 32'(words_written), 32'(ww));
    chk({tag, "_queue_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words_written"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two words, back-to-back bytes.
    send_len(16'd2, 1'b0);
    chk("t1_cpu_rst_loading", 32'(cpu_rst), 32'd1);
    send_word(32'h0, 32'h20080005, 1'b0);
    send_word(32'h4, 32'hAC080000, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_we_cleared", 32'(imem_we), 32'd0);
    check_done(16'd2, "t1");

    // Same image with random idle gaps between bytes.
    do_reset();
    send_len(16'd2, 1'b1);
    send_word(32'h0, 32'h20080005, 1'b1);
    send_word(32'h4, 32'hAC080000, 1'b1);
    @(posedge clk);
    #1;
    chk("t2_we_cleared", 32'(imem_we), 32'd0);
    check_done(16'd2, "t2");

    // Empty image completes right after the header; later bytes are refused.
    do_reset();
    send_len(16'd0, 1'b0);
    check_done(16'd0, "t3");
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t3_ff_refused", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    chk("t3_still_done", 32'(done), 32'd1);
    chk("t3_no_words", 32'(words_written), 32'd0);

    // Oversized length goes to error and stays there until reset.
    do_reset();
    send_len(16'(DEPTH + 1), 1'b0);
    $display("t4: error=%0b cpu_rst=%0b byte_ready=%0b", error, cpu_rst, byte_ready);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t4_byte_ready", 32'(byte_ready), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_error_held", 32'(error), 32'd1);
    chk("t4_no_words", 32'(words_written), 32'd0);
    do_reset();
    chk("t4_ready_after_rst", 32'(byte_ready), 32'd1);
    chk("t4_error_after_rst", 32'(error), 32'd0);

    // Full-capacity image.
    send_len(16'(DEPTH), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      send_word(32'(i * 4), {iv, 8'hA5, ~iv, 8'h3C}, 1'b0);
    end
    @(posedge clk);
    #1;
    check_done(16'(DEPTH), "t5");

    // Asynchronous reset in the middle of word 1 of a three-word image.
    do_reset();
    send_len(16'd3, 1'b0);
    send_word(32'h0, 32'hCAFEF00D, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("t6_words_before_rst", 32'(words_written), 32'd1);
    chk("t6_wdata_before_rst", imem_wdata, 32'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    check_reset_values("t6_async");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_len(16'd1, 1'b0);
    send_word(32'h0, 32'h12345678, 1'b0);
    @(posedge clk);
    #1;
    check_done(16'd1, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
